dp_ram_latency_resp: RTL and testbench
======================================

Name: dp_ram_latency_resp

Overview:
- Dual-port RAM responder, the memory end of the port A/B request protocol that the verification environment's driver initiates (WRITE / READ / IDLE per port per cycle).
- Each port has its own fixed read and write latency.
- Each port is fully pipelined: one request per port per cycle.
- Serves as the synthesizable DUT against which the reference model and scoreboard check latency-accurate behaviour.

Parameters:
- DATA_WIDTH, 8, data bits per word
- ADDRESS_WIDTH, 3, address bits; depth = 2**ADDRESS_WIDTH
- RD_LAT_A, 2, port A read latency in cycles (>=1)
- RD_LAT_B, 3, port B read latency in cycles (>=1)
- WR_LAT_A, 3, port A write latency in cycles (>=1)
- WR_LAT_B, 4, port B write latency in cycles (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- a_en  in  1  port A request valid (0 = IDLE)
- a_we  in  1  port A 1 = WRITE, 0 = READ (ignored when a_en=0)
- a_addr  in  ADDRESS_WIDTH  port A address
- a_wdata  in  DATA_WIDTH  port A write data
- a_rdata  out  DATA_WIDTH  port A read data, meaningful when a_rvalid=1
- a_rvalid  out  1  port A read data valid, one-cycle pulse per read
- a_wdone  out  1  port A write committed, one-cycle pulse per write
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid, b_wdone: same as port A, for port B
- coll  out  1  one-cycle pulse: A and B committed writes to the same address at the same edge

Behaviour:
- Reset (rst=1 at an edge):
  - all outputs 0;
  - all latency pipeline stages invalidated, so in-flight reads and writes are discarded and never produce rvalid/wdone;
  - every memory word cleared to 0.
  - A request presented in the same cycle as rst=1 is ignored.
- Request timing: a request is "in cycle n" when en=1 is sampled at the edge ending cycle n.
- Read, latency RL:
  - The array word is sampled at that edge.
  - The sample sees pre-update contents, i.e. before any write committing at the same edge (read-before-commit).
  - rdata/rvalid are registered outputs, asserted during cycle n+RL for exactly one cycle.
  - rdata holds its last value when rvalid=0.
- Write, latency WL:
  - Address and data are carried through the pipeline.
  - The array is updated at the edge ending cycle n+WL-1.
  - wdone is high during cycle n+WL.
  - A read of the same address in cycle n+WL-1 returns the old data; a read in cycle n+WL or later returns the new data.
- Throughput: back-to-back requests every cycle on both ports; no stalls, no backpressure. Outputs for consecutive requests appear in consecutive cycles, in order.
- Simultaneous commits:
  - A and B both commit to the same address at one edge: port A's data is stored, both wdone pulse, and coll pulses in the following cycle (aligned with the wdones).
  - Different addresses: both stored, coll=0.
- Simultaneous reads of any addresses on both ports: independent, no interaction.
- Address width: addresses use the full range with no wrap logic. Every address is in range by construction.
- Latency is fixed per parameter, not runtime-programmable.
- Elaboration check: any latency parameter <1 is a fatal error.

Decomposition:
- Shared package holds:
  - the existing state_t (WRITE, READ, IDLE) enum;
  - a packed request struct {we, addr, wdata};
  - the default width and latency constants, so the RTL and testbench share one source.
- One natural sub-module: latency_pipe, a parameterised DEPTH-stage valid+payload shift register with synchronous reset of the valid bits only.
- It is instantiated four times: read pipe A/B and write pipe A/B.
- The RAM array and the commit/collision logic stay in the top module.

Test Plan:
- Basic round trip, across ports: reset, then A WRITE addr 5 data 0xA5 in cycle 0 -> a_wdone in cycle 3. Then B READ addr 5 in cycle 3 -> b_rvalid in cycle 6 with b_rdata=0xA5.
- Read-before-commit:
  - A WRITE addr 2 data 0x3C in cycle 0.
  - A READ addr 2 in cycle 2 -> cycle 4 returns 0x00.
  - A READ addr 2 in cycle 3 -> cycle 5 returns 0x3C.
- Write collision:
  - B WRITE addr 1 data 0x22 in cycle 0; A WRITE addr 1 data 0x11 in cycle 1. Both commit at the edge ending cycle 3.
  - Expect a_wdone, b_wdone and coll high in cycle 4.
  - A later read of addr 1 returns 0x11.
- Streaming:
  - Preload words 0..7 with 0x10+i.
  - B READ addr 0..7 in cycles 10..17 -> b_rvalid continuously high in cycles 13..20, data 0x10..0x17 in order.
  - Concurrent A READs of the same addresses return the same data 2 cycles after each request.
- Reset mid-operation: A WRITE addr 4 data 0xFF in cycle 0, rst=1 in cycle 1 -> no a_wdone ever, and addr 4 reads back 0x00 after reset.
- Idle / no spurious output: 20 cycles with a_en=b_en=0 after traffic -> rvalid, wdone and coll stay 0; rdata holds its last value.

Source files
------------

// File: rtl/dp_ram_latency_resp_pkg.sv
// rtl/dp_ram_latency_resp_pkg.sv - shared types and default sizing for the dual-port latency RAM
package dp_ram_latency_resp_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_WIDTH = 3;
  localparam int DEF_RD_LAT_A      = 2;
  localparam int DEF_RD_LAT_B      = 3;
  localparam int DEF_WR_LAT_A      = 3;
  localparam int DEF_WR_LAT_B      = 4;

  typedef enum logic [1:0] {
    WRITE,
    READ,
    IDLE
  } state_t;

  typedef struct packed {
    logic                         we;
    logic [DEF_ADDRESS_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]    wdata;
  } req_t;

endpackage

// File: rtl/dp_ram_latency_resp_latency_pipe.sv
// rtl/dp_ram_latency_resp_latency_pipe.sv - DEPTH-stage valid+payload shift register
// DEPTH=0 is a combinational bypass; payload of a stage only moves when its input is valid.
module dp_ram_latency_resp_latency_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_stages
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_valid ? in_data : data_q[0];
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = valid_q[k-1] ? data_q[k-1] : data_q[k];
      end
      if (rst) begin
        valid_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/dp_ram_latency_resp.sv
// rtl/dp_ram_latency_resp.sv - dual-port RAM responder with fixed per-port read/write latencies
// Reads sample the array at request time; writes travel WL-1 stages and commit, A winning ties.
module dp_ram_latency_resp
  import dp_ram_latency_resp_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int RD_LAT_A      = DEF_RD_LAT_A,
  parameter int RD_LAT_B      = DEF_RD_LAT_B,
  parameter int WR_LAT_A      = DEF_WR_LAT_A,
  parameter int WR_LAT_B      = DEF_WR_LAT_B
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_en,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  output logic                     a_rvalid,
  output logic                     a_wdone,
  input  logic                     b_en,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     b_rvalid,
  output logic                     b_wdone,
  output logic                     coll
);

  localparam int WORDS = 2 ** ADDRESS_WIDTH;
  localparam int WP_W  = ADDRESS_WIDTH + DATA_WIDTH;

  if (RD_LAT_A < 1 || RD_LAT_B < 1 || WR_LAT_A < 1 || WR_LAT_B < 1) begin : g_lat_check
    $fatal(1, "dp_ram_latency_resp: every latency parameter must be >= 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] mem_d [WORDS];

  logic                  ra_valid, rb_valid;
  logic [DATA_WIDTH-1:0] ra_data, rb_data;
  logic                  wa_valid, wb_valid;
  logic [WP_W-1:0]       wa_pay, wb_pay;
  logic [ADDRESS_WIDTH-1:0] wa_addr, wb_addr;
  logic [DATA_WIDTH-1:0]    wa_data, wb_data;

  logic a_wdone_q, a_wdone_d, b_wdone_q, b_wdone_d, coll_q, coll_d;
  logic a_rd_seen_q, a_rd_seen_d, b_rd_seen_q, b_rd_seen_d;

  dp_ram_latency_resp_latency_pipe #(.DEPTH(RD_LAT_A), .WIDTH(DATA_WIDTH)) u_rd_pipe_a (
    .clk(clk), .rst(rst), .in_valid(a_en & ~a_we & ~rst), .in_data(mem_q[a_addr]),
    .out_valid(ra_valid), .out_data(ra_data)
  );

  dp_ram_latency_resp_latency_pipe #(.DEPTH(RD_LAT_B), .WIDTH(DATA_WIDTH)) u_rd_pipe_b (
    .clk(clk), .rst(rst), .in_valid(b_en & ~b_we & ~rst), .in_data(mem_q[b_addr]),
    .out_valid(rb_valid), .out_data(rb_data)
  );

  dp_ram_latency_resp_latency_pipe #(.DEPTH(WR_LAT_A - 1), .WIDTH(WP_W)) u_wr_pipe_a (
    .clk(clk), .rst(rst), .in_valid(a_en & a_we & ~rst), .in_data({a_addr, a_wdata}),
    .out_valid(wa_valid), .out_data(wa_pay)
  );

  dp_ram_latency_resp_latency_pipe #(.DEPTH(WR_LAT_B - 1), .WIDTH(WP_W)) u_wr_pipe_b (
    .clk(clk), .rst(rst), .in_valid(b_en & b_we & ~rst), .in_data({b_addr, b_wdata}),
    .out_valid(wb_valid), .out_data(wb_pay)
  );

  assign wa_addr = wa_pay[WP_W-1:DATA_WIDTH];
  assign wa_data = wa_pay[DATA_WIDTH-1:0];
  assign wb_addr = wb_pay[WP_W-1:DATA_WIDTH];
  assign wb_data = wb_pay[DATA_WIDTH-1:0];

  // B is applied first so that A overwrites it on a same-address commit.
  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_d[i] = '0;
      end
    end else begin
      if (wb_valid) begin
        mem_d[wb_addr] = wb_data;
      end
      if (wa_valid) begin
        mem_d[wa_addr] = wa_data;
      end
    end
  end

  always_comb begin
    a_wdone_d   = ~rst & wa_valid;
    b_wdone_d   = ~rst & wb_valid;
    coll_d      = ~rst & wa_valid & wb_valid & (wa_addr == wb_addr);
    a_rd_seen_d = ~rst & (a_rd_seen_q | ra_valid);
    b_rd_seen_d = ~rst & (b_rd_seen_q | rb_valid);
  end

  always_ff @(posedge clk) begin
    mem_q       <= mem_d;
    a_wdone_q   <= a_wdone_d;
    b_wdone_q   <= b_wdone_d;
    coll_q      <= coll_d;
    a_rd_seen_q <= a_rd_seen_d;
    b_rd_seen_q <= b_rd_seen_d;
  end

  // Pipe payloads survive reset, so read data is masked until the first post-reset read lands.
  assign a_rdata  = (a_rd_seen_q | ra_valid) ? ra_data : '0;
  assign b_rdata  = (b_rd_seen_q | rb_valid) ? rb_data : '0;
  assign a_rvalid = ra_valid;
  assign b_rvalid = rb_valid;
  assign a_wdone  = a_wdone_q;
  assign b_wdone  = b_wdone_q;
  assign coll     = coll_q;

endmodule

// File: tb/tb_dp_ram_latency_resp.sv
// tb/tb_dp_ram_latency_resp.sv - scoreboard bench for dp_ram_latency_resp
module tb_dp_ram_latency_resp;
  import dp_ram_latency_resp_pkg::*;

  localparam int DW  = DEF_DATA_WIDTH;
  localparam int AW  = DEF_ADDRESS_WIDTH;
  localparam int RLA = DEF_RD_LAT_A;
  localparam int RLB = DEF_RD_LAT_B;
  localparam int WLA = DEF_WR_LAT_A;
  localparam int WLB = DEF_WR_LAT_B;
  localparam int NW  = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, a_wdone, b_rvalid, b_wdone, coll;

  always #5 clk = ~clk;

  dp_ram_latency_resp #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .RD_LAT_A(RLA), .RD_LAT_B(RLB), .WR_LAT_A(WLA), .WR_LAT_B(WLB)
  ) dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_wdone(a_wdone),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_wdone(b_wdone),
    .coll(coll)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       a_rdq[$], b_rdq[$];
  int            a_wq[$], b_wq[$], coll_q[$];
  logic [DW-1:0] model_mem [NW];
  req_t          pend_a [int];
  req_t          pend_b [int];
  logic [DW-1:0] last_a = '0, last_b = '0;
  int            cyc = 0, tests = 0, fails = 0;
  bit            rst_edge = 0, mon_en = 0;
  state_t        op_a = IDLE, op_b = IDLE;
  req_t          req_a = '0, req_b = '0;
  bit            rst_req = 1;
  rd_exp_t       ea, eb;
  bit            exp_bit;

  // Reference behaviour of one clock edge ending cycle 'cyc'.
  function automatic void model_edge();
    if (rst_req) begin
      for (int i = 0; i < NW; i++) model_mem[i] = '0;
      pend_a.delete(); pend_b.delete();
      a_rdq.delete(); b_rdq.delete(); a_wq.delete(); b_wq.delete(); coll_q.delete();
      last_a = '0; last_b = '0;
      rst_edge = 1;
      return;
    end
    if (op_a == READ) a_rdq.push_back('{cyc + RLA, model_mem[req_a.addr]});
    if (op_b == READ) b_rdq.push_back('{cyc + RLB, model_mem[req_b.addr]});
    if (op_a == WRITE) pend_a[cyc + WLA - 1] = req_a;
    if (op_b == WRITE) pend_b[cyc + WLB - 1] = req_b;
    if (pend_b.exists(cyc)) begin
      model_mem[pend_b[cyc].addr] = pend_b[cyc].wdata;
      b_wq.push_back(cyc + 1);
    end
    if (pend_a.exists(cyc)) begin
      model_mem[pend_a[cyc].addr] = pend_a[cyc].wdata;
      a_wq.push_back(cyc + 1);
    end
    if (pend_a.exists(cyc) && pend_b.exists(cyc) && pend_a[cyc].addr == pend_b[cyc].addr)
      coll_q.push_back(cyc + 1);
    pend_a.delete(cyc);
    pend_b.delete(cyc);
  endfunction

  task automatic step();
    a_en    = (op_a != IDLE);
    a_we    = (op_a == WRITE);
    a_addr  = req_a.addr;
    a_wdata = req_a.wdata;
    b_en    = (op_b != IDLE);
    b_we    = (op_b == WRITE);
    b_addr  = req_b.addr;
    b_wdata = req_b.wdata;
    rst     = rst_req;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic go(input state_t oa, input int aa, input int ad,
                    input state_t ob, input int ba, input int bd);
    logic [31:0] v;
    op_a = oa; op_b = ob; rst_req = 0;
    v = aa; req_a.addr = v[AW-1:0];
    v = ad; req_a.wdata = v[DW-1:0];
    req_a.we = (oa == WRITE);
    v = ba; req_b.addr = v[AW-1:0];
    v = bd; req_b.wdata = v[DW-1:0];
    req_b.we = (ob == WRITE);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) go(IDLE, 0, 0, IDLE, 0, 0);
  endtask

  task automatic do_reset();
    op_a = IDLE; op_b = IDLE; rst_req = 1;
    step();
    rst_req = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) begin
        tests++;
        if ({a_rvalid, a_wdone, b_rvalid, b_wdone, coll, a_rdata, b_rdata} !== '0) begin
          fails++;
          $display("FAIL reset_outputs cyc=%0d got rv=%b/%b wd=%b/%b coll=%b rdata=%h/%h expected all zero",
                   cyc, a_rvalid, b_rvalid, a_wdone, b_wdone, coll, a_rdata, b_rdata);
        end
        rst_edge = 0;
      end

      tests++;
      if (a_rdq.size() > 0 && a_rdq[0].cyc == cyc) begin
        ea = a_rdq.pop_front();
        last_a = ea.data;
        if (a_rvalid !== 1'b1 || a_rdata !== ea.data) begin
          fails++;
          $display("FAIL a_read cyc=%0d got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                   cyc, a_rvalid, a_rdata, ea.data);
        end
      end else if (a_rvalid !== 1'b0 || a_rdata !== last_a) begin
        fails++;
        $display("FAIL a_idle_hold cyc=%0d got rvalid=%b rdata=%h expected rvalid=0 rdata=%h",
                 cyc, a_rvalid, a_rdata, last_a);
      end

      tests++;
      if (b_rdq.size() > 0 && b_rdq[0].cyc == cyc) begin
        eb = b_rdq.pop_front();
        last_b = eb.data;
        if (b_rvalid !== 1'b1 || b_rdata !== eb.data) begin
          fails++;
          $display("FAIL b_read cyc=%0d got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                   cyc, b_rvalid, b_rdata, eb.data);
        end
      end else if (b_rvalid !== 1'b0 || b_rdata !== last_b) begin
        fails++;
        $display("FAIL b_idle_hold cyc=%0d got rvalid=%b rdata=%h expected rvalid=0 rdata=%h",
                 cyc, b_rvalid, b_rdata, last_b);
      end

      exp_bit = (a_wq.size() > 0 && a_wq[0] == cyc);
      if (exp_bit) void'(a_wq.pop_front());
      tests++;
      if (a_wdone !== exp_bit) begin
        fails++;
        $display("FAIL a_wdone cyc=%0d got %b expected %b", cyc, a_wdone, exp_bit);
      end

      exp_bit = (b_wq.size() > 0 && b_wq[0] == cyc);
      if (exp_bit) void'(b_wq.pop_front());
      tests++;
      if (b_wdone !== exp_bit) begin
        fails++;
        $display("FAIL b_wdone cyc=%0d got %b expected %b", cyc, b_wdone, exp_bit);
      end

      exp_bit = (coll_q.size() > 0 && coll_q[0] == cyc);
      if (exp_bit) void'(coll_q.pop_front());
      tests++;
      if (coll !== exp_bit) begin
        fails++;
        $display("FAIL coll cyc=%0d got %b expected %b", cyc, coll, exp_bit);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got no end of stimulus expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pending;
    do_reset();
    mon_en = 1;
    do_reset();

    // round trip across ports
    go(WRITE, 5, 8'hA5, IDLE, 0, 0);
    idle(2);
    go(IDLE, 0, 0, READ, 5, 0);
    idle(4);

    // read-before-commit
    go(WRITE, 2, 8'h3C, IDLE, 0, 0);
    idle(1);
    go(READ, 2, 0, IDLE, 0, 0);
    go(READ, 2, 0, IDLE, 0, 0);
    idle(3);

    // same-address commit collision, A wins
    go(IDLE, 0, 0, WRITE, 1, 8'h22);
    go(WRITE, 1, 8'h11, IDLE, 0, 0);
    idle(3);
    go(READ, 1, 0, READ, 1, 0);
    idle(4);

    // streaming
    for (int i = 0; i < NW; i++) go(WRITE, i, 8'h10 + i, IDLE, 0, 0);
    idle(3);
    for (int i = 0; i < NW; i++) go(READ, i, 0, READ, i, 0);
    idle(4);

    // reset with a write in flight
    go(WRITE, 4, 8'hFF, IDLE, 0, 0);
    do_reset();
    idle(4);
    go(READ, 4, 0, READ, 4, 0);
    idle(4);

    // randomized traffic with rare resets
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        go(state_t'($urandom_range(0, 2)), $urandom_range(0, NW - 1), $urandom_range(0, 255),
           state_t'($urandom_range(0, 2)), $urandom_range(0, NW - 1), $urandom_range(0, 255));
      end
    end

    // quiet period: no spurious pulses, rdata holds
    idle(20);

    pending = a_rdq.size() + b_rdq.size() + a_wq.size() + b_wq.size() + coll_q.size();
    tests++;
    if (pending != 0) begin
      fails++;
      $display("FAIL drain got %0d outstanding responses expected 0", pending);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
